// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// hazard_pkg : shared types and codes for the multi-cycle hazard controller.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MC_WAIT  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int RESULT_SRC_LOAD_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
//------------------------------------------------------------------------------
// hazard_fwd_sel : E-stage operand forwarding select for one source operand.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd_sel
);

    logic w_rs_nonzero;

    assign w_rs_nonzero = (rs_e != '0);

    // The younger M-stage result wins over the W-stage result.
    always_comb begin
        fwd_sel = FWD_RF;
        if (w_rs_nonzero && reg_write_m && (rs_e == rd_m)) begin
            fwd_sel = FWD_MEM;
        end else if (w_rs_nonzero && reg_write_w && (rs_e == rd_w)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
//------------------------------------------------------------------------------
// hazard_ctrl_mc : pipeline hazard unit with forwarding, load-use, branch flush,
//                  multi-cycle/memory wait handling, watchdog and stall counter.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [1:0]        result_src_e,
    input  logic              pc_src_e,
    input  logic              mc_start_e,
    input  logic              mc_done,
    input  logic              dmem_req_m,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_count,
    output logic              timeout_err
);

    localparam int              WC_W    = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] C_WC_MAX = WC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] C_WC_ERR = WC_W'(TIMEOUT - 2);

    hz_state_t       r_state;
    hz_state_t       w_state_next;
    logic [WC_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic            r_timeout_err;

    logic w_mem_stall;
    logic w_mc_stall;
    logic w_lw_stall;
    logic w_take;
    logic w_stay_wait;
    logic w_unused_src;

    assign w_unused_src = result_src_e[1];

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (forward_a_e)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (forward_b_e)
    );

    assign w_mem_stall = dmem_req_m && !dmem_ready;
    assign w_mc_stall  = mc_start_e && !mc_done && !w_mem_stall;
    assign w_lw_stall  = result_src_e[RESULT_SRC_LOAD_BIT] && (rd_e != '0)
                         && ((rs1_d == rd_e) || (rs2_d == rd_e))
                         && !w_mem_stall && !w_mc_stall;
    // A branch resolved in E only redirects once E actually advances.
    assign w_take      = pc_src_e && !w_mem_stall && !w_mc_stall;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (w_mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (w_mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (w_take) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_next = MEM_WAIT;
                end else if (w_mc_stall) begin
                    w_state_next = MC_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_state_next = RUN;
                end
            end
            MC_WAIT: begin
                if (w_mem_stall) begin
                    w_state_next = MEM_WAIT;
                end else if (!w_mc_stall) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    assign w_stay_wait = (w_state_next == r_state) && (r_state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Watchdog: error flags when the counter is about to reach TIMEOUT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_stay_wait) begin
                if (r_wait_cnt != C_WC_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt >= C_WC_ERR) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (stall_f && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl_mc : directed self-checking bench with a behavioural model.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl_mc;

    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              reg_write_m, reg_write_w;
    logic [1:0]        result_src_e;
    logic              pc_src_e, mc_start_e, mc_done, dmem_req_m, dmem_ready;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_m, flush_w;
    logic [1:0]        forward_a_e, forward_b_e;
    logic [CNT_W-1:0]  stall_count;
    logic              timeout_err;

    int tests = 0;
    int fails = 0;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e),
        .mc_start_e(mc_start_e), .mc_done(mc_done),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_count(stall_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected combinational behaviour, straight from the rules.
    function automatic logic [1:0] fwd_of(input logic [REG_AW-1:0] rs);
        if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
        if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
        return 2'b00;
    endfunction

    logic e_mem, e_mc, e_lw, e_take;
    logic [7:0] e_vec; // {sf,sd,se,sm,fd,fe,fm,fw}
    always_comb begin
        e_mem  = dmem_req_m && !dmem_ready;
        e_mc   = mc_start_e && !mc_done && !e_mem;
        e_lw   = result_src_e[0] && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e) && !e_mem && !e_mc;
        e_take = pc_src_e && !e_mem && !e_mc;
        e_vec  = 8'b0;
        if (e_mem)       e_vec = 8'b1111_0001;
        else if (e_mc)   e_vec = 8'b1110_0010;
        else if (e_take) e_vec = 8'b0000_1100;
        else if (e_lw)   e_vec = 8'b1100_0100;
    end

    // Model state: length of the current unbroken wait of one kind.
    int m_kind = 0;
    int m_len  = 0;
    int m_cnt  = 0;
    logic m_err = 1'b0;
    always @(posedge clk or posedge rst) begin
        int kind;
        int nl;
        if (rst) begin
            m_kind <= 0;
            m_len  <= 0;
            m_cnt  <= 0;
            m_err  <= 1'b0;
        end else begin
            kind = e_mem ? 1 : (e_mc ? 2 : 0);
            nl   = (kind == 0) ? 0 : ((kind == m_kind) ? m_len + 1 : 1);
            m_kind <= kind;
            m_len  <= nl;
            if (nl >= TIMEOUT) m_err <= 1'b1;
            if (e_vec[7] && m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("vec",    {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}, e_vec);
            check("fwd_a",  forward_a_e, fwd_of(rs1_e));
            check("fwd_b",  forward_b_e, fwd_of(rs2_e));
            check("count",  stall_count, m_cnt);
            check("tmo",    timeout_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; result_src_e = 0; pc_src_e = 0;
        mc_start_e = 0; mc_done = 0; dmem_req_m = 0; dmem_ready = 0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_count", stall_count, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_stall_f", stall_f, 0);
        check("rst_fwd_a", forward_a_e, 0);

        // Forwarding priority and x0 exclusion
        tick();
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
        #1 check("fwd_m_prio", forward_a_e, 2);
        tick();
        rs1_e = 0; rs2_e = 9; rd_w = 9;
        #1 check("fwd_x0", forward_a_e, 0);
        check("fwd_w", forward_b_e, 1);

        // Load-use, then with rd_e=0
        tick();
        idle();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #1 check("lw_sf", stall_f, 1);
        check("lw_sd", stall_d, 1);
        check("lw_fe", flush_e, 1);
        check("lw_se", stall_e, 0);
        tick();
        check("lw_count", stall_count, 1);
        rd_e = 0;
        #1 check("lw_x0", stall_f, 0);

        // Branch overrides load-use
        tick();
        rd_e = 7; pc_src_e = 1;
        #1 check("br_fd", flush_d, 1);
        check("br_fe", flush_e, 1);
        check("br_sf", stall_f, 0);

        // Memory wait of three cycles
        tick();
        idle();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mem_sm", stall_m, 1);
            check("mem_fw", flush_w, 1);
            tick();
        end
        dmem_ready = 1;
        #1 check("mem_adv", stall_f, 0);
        tick();
        idle();
        check("mem_count", stall_count, 4);

        // Multi-cycle op with a pending branch
        mc_start_e = 1; pc_src_e = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("mc_se", stall_e, 1);
            check("mc_fm", flush_m, 1);
            check("mc_fd_low", flush_d, 0);
            tick();
        end
        mc_done = 1;
        #1 check("mc_fd", flush_d, 1);
        check("mc_sf", stall_f, 0);
        tick();
        idle();
        check("mc_count", stall_count, 8);
        tick();

        // Watchdog and counter saturation
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 7) check("tmo_pre", timeout_err, 0);
            if (i == 8) check("tmo_set", timeout_err, 1);
        end
        check("sat_count", stall_count, 63);
        #2 rst = 1'b1;
        #1 check("arst_count", stall_count, 0);
        check("arst_tmo", timeout_err, 0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("tmo2_pre", timeout_err, 0);
            if (i == 8) check("tmo2_set", timeout_err, 1);
        end
        check("post_rst_count", stall_count, 8);
        idle();
        repeat (3) tick();
        check("tmo_sticky", timeout_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
